// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded control word and operands, gates control on the ARM condition.
// Define COND_CHECK_EN to enable condition evaluation with NZCV forwarding from EX; otherwise every instruction is AL.
module id_ex_stage_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        cond_in,
    input  logic [3:0]        status_in,
    input  logic [3:0]        status_fwd_in,
    input  logic [3:0]        alu_command_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              wb_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm24_in,
    input  logic [3:0]        dest_in,
    output logic              ex_valid,
    output logic [3:0]        alu_command,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_en,
    output logic              b,
    output logic              s,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm24,
    output logic [3:0]        dest,
    output logic              carry_out
);

    logic [3:0] flags_eff_p0;
    logic       pass_p0;
    logic       vld_p0;

`ifdef COND_CHECK_EN
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // A status-setting instruction in EX has not committed its flags yet, so take them from the ALU
    assign flags_eff_p0 = (ex_valid && s) ? status_fwd_in : status_in;
    assign pass_p0      = cond_pass(cond_in, flags_eff_p0);
`else
    logic unused_cond_inputs;
    assign unused_cond_inputs = ^{cond_in, status_fwd_in};
    assign flags_eff_p0       = status_in;
    assign pass_p0            = 1'b1;
`endif

    assign vld_p0 = id_valid && pass_p0;

    // ID -> EX boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            alu_command   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            wb_en         <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            pc            <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm24  <= '0;
            dest          <= '0;
            carry_out     <= 1'b0;
        end else if (flush) begin
            ex_valid      <= 1'b0;
            alu_command   <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            wb_en         <= 1'b0;
            b             <= 1'b0;
            s             <= 1'b0;
            pc            <= '0;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm24  <= '0;
            dest          <= '0;
            carry_out     <= 1'b0;
        end else if (!freeze) begin
            ex_valid      <= vld_p0;
            alu_command   <= vld_p0 ? alu_command_in : 4'd0;
            mem_read      <= vld_p0 && mem_read_in;
            mem_write     <= vld_p0 && mem_write_in;
            wb_en         <= vld_p0 && wb_en_in;
            b             <= vld_p0 && b_in;
            s             <= vld_p0 && s_in;
            pc            <= pc_in;
            val_rn        <= val_rn_in;
            val_rm        <= val_rm_in;
            imm           <= imm_in;
            shift_operand <= shift_operand_in;
            signed_imm24  <= signed_imm24_in;
            dest          <= dest_in;
            carry_out     <= flags_eff_p0[1];
        end
    end

endmodule
